// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and default widths for the data-cache miss
//                controller: the controller state encoding and the default
//                data, address and performance-counter widths.
//  Revision    : 1.0  initial release
// ============================================================================
package dcache_pkg;

    localparam int c_DATA_WIDTH    = 32;
    localparam int c_ADDRESS_WIDTH = 32;
    localparam int c_CNT_WIDTH     = 32;

    // Controller states, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dcache_state_t;

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that increments by one on each cycle with i_inc
//                high and holds at all-ones instead of wrapping.
//  Ports       : clk     - clock
//                rst     - synchronous active-high reset (count to zero)
//                i_inc   - increment request
//                o_count - current count
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_miss_ctrl
//  Description : Memory-stage data-cache sequencer. A load miss or any store
//                stalls the pipeline and runs one request/acknowledge
//                transaction with the backing data memory. Loads then get the
//                refill word and a one-cycle cache fill command.
//  Build macro : DCACHE_PERF_CNT_EN - adds saturating HitCnt/MissCnt ports.
//  Ports       : CLK, RST            - clock, synchronous active-high reset
//                MemReadM/MemWriteM  - memory-stage load / store
//                AddrM, WriteDataM   - memory-stage address and store data
//                hit                 - cache tag match for AddrM
//                MemAck, MemRData    - backing-memory completion and data
//                StallM              - pipeline freeze
//                MemReq/MemWe/MemAddr/MemWData - backing-memory request
//                FillEn, RefillValid, RefillData - load refill outputs
//                HitCnt, MissCnt     - performance counters (macro only)
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_miss_ctrl
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH    = c_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = c_ADDRESS_WIDTH,
    parameter int CNT_WIDTH     = c_CNT_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     MemReadM,
    input  logic                     MemWriteM,
    input  logic [ADDRESS_WIDTH-1:0] AddrM,
    input  logic [DATA_WIDTH-1:0]    WriteDataM,
    input  logic                     hit,
    input  logic                     MemAck,
    input  logic [DATA_WIDTH-1:0]    MemRData,
    output logic                     StallM,
    output logic                     MemReq,
    output logic                     MemWe,
    output logic [ADDRESS_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0]    MemWData,
    output logic                     FillEn,
    output logic                     RefillValid,
    output logic [DATA_WIDTH-1:0]    RefillData
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     HitCnt,
    output logic [CNT_WIDTH-1:0]     MissCnt
`endif
);

    dcache_state_t            r_state;
    logic                     r_memReq;
    logic                     r_memWe;
    logic [ADDRESS_WIDTH-1:0] r_memAddr;
    logic [DATA_WIDTH-1:0]    r_memWData;
    logic                     r_fillEn;
    logic                     r_refillValid;
    logic [DATA_WIDTH-1:0]    r_refillData;

    logic w_start;
    logic w_idle;

    // A store always goes to backing memory (write-through); a simultaneous
    // read and write is therefore treated as a store.
    assign w_start = MemWriteM | (MemReadM & ~hit);
    assign w_idle  = (r_state == IDLE);

    // Combinational so the stall rises in the very cycle the miss is seen.
    assign StallM = (w_idle & w_start) | (r_state == BUSY);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_memReq      <= 1'b0;
            r_memWe       <= 1'b0;
            r_memAddr     <= '0;
            r_memWData    <= '0;
            r_fillEn      <= 1'b0;
            r_refillValid <= 1'b0;
            r_refillData  <= '0;
        end else begin
            // Fill command and refill select are single-cycle (DONE only).
            r_fillEn      <= 1'b0;
            r_refillValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state    <= BUSY;
                        r_memReq   <= 1'b1;
                        r_memWe    <= MemWriteM;
                        r_memAddr  <= AddrM;
                        r_memWData <= WriteDataM;
                    end
                end
                BUSY: begin
                    if (MemAck) begin
                        r_state  <= DONE;
                        r_memReq <= 1'b0;
                        if (!r_memWe) begin
                            r_refillData  <= MemRData;
                            r_fillEn      <= 1'b1;
                            r_refillValid <= 1'b1;
                        end
                    end
                end
                // The stalled instruction leaves M on this edge, so start is
                // deliberately not looked at here to avoid a re-issue.
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state  <= IDLE;
                    r_memReq <= 1'b0;
                end
            endcase
        end
    end

    assign MemReq      = r_memReq;
    assign MemWe       = r_memWe;
    assign MemAddr     = r_memAddr;
    assign MemWData    = r_memWData;
    assign FillEn      = r_fillEn;
    assign RefillValid = r_refillValid;
    assign RefillData  = r_refillData;

`ifdef DCACHE_PERF_CNT_EN
    logic w_hitInc;
    logic w_missInc;

    assign w_hitInc  = w_idle & MemReadM & hit & ~MemWriteM;
    // Only a load can start a transaction without MemWriteM.
    assign w_missInc = w_idle & MemReadM & ~hit & ~MemWriteM;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_hitCnt (
        .clk     (CLK),
        .rst     (RST),
        .i_inc   (w_hitInc),
        .o_count (HitCnt)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_missCnt (
        .clk     (CLK),
        .rst     (RST),
        .i_inc   (w_missInc),
        .o_count (MissCnt)
    );
`endif

endmodule : dcache_miss_ctrl
`default_nettype wire

// File: tb/tb_dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_miss_ctrl
//  Description : Self-checking bench for dcache_miss_ctrl. A table of
//                per-cycle input records with hand-computed expected outputs
//                is applied in order, followed by a hand-written reset-in-BUSY
//                sequence. Counter checks are active with DCACHE_PERF_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_miss_ctrl;

    localparam int c_CNT_W = 2;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hit;
        logic        ack;
        logic [31:0] rdata;
        logic        eStall;
        logic        eReq;
        logic        eWe;
        logic [31:0] eAddr;
        logic [31:0] eWData;
        logic        eFill;
        logic        eRv;
        logic [31:0] eRefill;
        logic [1:0]  eHit;
        logic [1:0]  eMiss;
    } vec_t;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic        r_memReadM;
    logic        r_memWriteM;
    logic [31:0] r_addrM;
    logic [31:0] r_writeDataM;
    logic        r_hit;
    logic        r_memAck;
    logic [31:0] r_memRData;

    logic        w_stallM;
    logic        w_memReq;
    logic        w_memWe;
    logic [31:0] w_memAddr;
    logic [31:0] w_memWData;
    logic        w_fillEn;
    logic        w_refillValid;
    logic [31:0] w_refillData;
`ifdef DCACHE_PERF_CNT_EN
    logic [c_CNT_W-1:0] w_hitCnt;
    logic [c_CNT_W-1:0] w_missCnt;
`endif

    int nCmp  = 0;
    int nFail = 0;

    vec_t tv [27];

    dcache_miss_ctrl #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .CNT_WIDTH     (c_CNT_W)
    ) dut (
        .CLK         (r_clk),
        .RST         (r_rst),
        .MemReadM    (r_memReadM),
        .MemWriteM   (r_memWriteM),
        .AddrM       (r_addrM),
        .WriteDataM  (r_writeDataM),
        .hit         (r_hit),
        .MemAck      (r_memAck),
        .MemRData    (r_memRData),
        .StallM      (w_stallM),
        .MemReq      (w_memReq),
        .MemWe       (w_memWe),
        .MemAddr     (w_memAddr),
        .MemWData    (w_memWData),
        .FillEn      (w_fillEn),
        .RefillValid (w_refillValid),
        .RefillData  (w_refillData)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .HitCnt      (w_hitCnt),
        .MissCnt     (w_missCnt)
`endif
    );

    always #5 r_clk = ~r_clk;

    function automatic vec_t mk(
        input logic [31:0] rd, input logic [31:0] wr, input logic [31:0] addr,
        input logic [31:0] wdata, input logic [31:0] hit, input logic [31:0] ack,
        input logic [31:0] rdata, input logic [31:0] stall, input logic [31:0] req,
        input logic [31:0] we, input logic [31:0] maddr, input logic [31:0] mwd,
        input logic [31:0] fill, input logic [31:0] rv, input logic [31:0] refill,
        input logic [31:0] h, input logic [31:0] m);
        vec_t v;
        v.rd = rd[0];       v.wr = wr[0];       v.addr = addr;
        v.wdata = wdata;    v.hit = hit[0];     v.ack = ack[0];
        v.rdata = rdata;    v.eStall = stall[0]; v.eReq = req[0];
        v.eWe = we[0];      v.eAddr = maddr;    v.eWData = mwd;
        v.eFill = fill[0];  v.eRv = rv[0];      v.eRefill = refill;
        v.eHit = h[1:0];    v.eMiss = m[1:0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic hit, input logic ack,
                         input logic [31:0] rdata);
        r_memReadM   = rd;
        r_memWriteM  = wr;
        r_addrM      = addr;
        r_writeDataM = wdata;
        r_hit        = hit;
        r_memAck     = ack;
        r_memRData   = rdata;
    endtask

    initial begin
        // rd wr addr wdata hit ack rdata | stall req we maddr mwd fill rv refill | hit miss
        tv[0]  = mk(0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0,            0,0);
        tv[1]  = mk(1,0,'h100,0,1,0,0,                      0,0,0,0,0,0,0,0,            0,0);
        tv[2]  = mk(0,0,0,0,0,1,'h1111,                     0,0,0,0,0,0,0,0,            1,0);
        tv[3]  = mk(0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0,            1,0);
        tv[4]  = mk(1,0,'h200,0,0,0,0,                      1,0,0,0,0,0,0,0,            1,0);
        tv[5]  = mk(1,0,'h200,0,0,0,0,                      1,1,0,'h200,0,0,0,0,        1,1);
        tv[6]  = mk(1,0,'h200,0,0,0,0,                      1,1,0,'h200,0,0,0,0,        1,1);
        tv[7]  = mk(1,0,'h200,0,0,1,'hDEADBEEF,             1,1,0,'h200,0,0,0,0,        1,1);
        tv[8]  = mk(1,0,'h200,0,0,0,0,                      0,0,0,0,0,1,1,'hDEADBEEF,   1,1);
        tv[9]  = mk(0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0,            1,1);
        tv[10] = mk(0,1,'h300,'h12345678,1,0,0,             1,0,0,0,0,0,0,0,            1,1);
        tv[11] = mk(0,1,'h300,'h12345678,1,0,0,             1,1,1,'h300,'h12345678,0,0,0, 1,1);
        tv[12] = mk(0,1,'h300,'h12345678,1,1,'hCAFE0000,    1,1,1,'h300,'h12345678,0,0,0, 1,1);
        tv[13] = mk(0,1,'h300,'h12345678,1,0,0,             0,0,0,0,0,0,0,0,            1,1);
        tv[14] = mk(1,1,'h500,'h55,0,0,0,                   1,0,0,0,0,0,0,0,            1,1);
        tv[15] = mk(1,1,'h500,'h55,0,1,'hFFFFFFFF,          1,1,1,'h500,'h55,0,0,0,     1,1);
        tv[16] = mk(1,1,'h500,'h55,0,0,0,                   0,0,0,0,0,0,0,0,            1,1);
        tv[17] = mk(1,0,'h400,0,0,0,0,                      1,0,0,0,0,0,0,0,            1,1);
        tv[18] = mk(1,0,'h400,0,0,1,'hA0A00400,             1,1,0,'h400,0,0,0,0,        1,2);
        tv[19] = mk(1,0,'h400,0,0,0,0,                      0,0,0,0,0,1,1,'hA0A00400,   1,2);
        tv[20] = mk(1,0,'h404,0,0,0,0,                      1,0,0,0,0,0,0,0,            1,2);
        tv[21] = mk(1,0,'h404,0,0,1,'hB0B00404,             1,1,0,'h404,0,0,0,0,        1,3);
        tv[22] = mk(1,0,'h404,0,0,0,0,                      0,0,0,0,0,1,1,'hB0B00404,   1,3);
        tv[23] = mk(1,0,'h408,0,0,0,0,                      1,0,0,0,0,0,0,0,            1,3);
        tv[24] = mk(1,0,'h408,0,0,1,'h00000408,             1,1,0,'h408,0,0,0,0,        1,3);
        tv[25] = mk(1,0,'h408,0,0,0,0,                      0,0,0,0,0,1,1,'h00000408,   1,3);
        tv[26] = mk(0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0,            1,3);

        r_rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge r_clk);

        // Inputs change on the falling edge; outputs are sampled 1 time unit
        // later, well before the next rising edge.
        for (int i = 0; i < 27; i++) begin
            @(negedge r_clk);
            r_rst = 1'b0;
            drive(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].hit, tv[i].ack, tv[i].rdata);
            #1;
            check($sformatf("row%0d StallM", i),      32'(w_stallM),      32'(tv[i].eStall));
            check($sformatf("row%0d MemReq", i),      32'(w_memReq),      32'(tv[i].eReq));
            check($sformatf("row%0d FillEn", i),      32'(w_fillEn),      32'(tv[i].eFill));
            check($sformatf("row%0d RefillValid", i), 32'(w_refillValid), 32'(tv[i].eRv));
            if (tv[i].eReq || i == 0) begin
                check($sformatf("row%0d MemWe", i),    32'(w_memWe), 32'(tv[i].eWe));
                check($sformatf("row%0d MemAddr", i),  w_memAddr,    tv[i].eAddr);
                check($sformatf("row%0d MemWData", i), w_memWData,   tv[i].eWData);
            end
            if (tv[i].eFill || i == 0) begin
                check($sformatf("row%0d RefillData", i), w_refillData, tv[i].eRefill);
            end
`ifdef DCACHE_PERF_CNT_EN
            check($sformatf("row%0d HitCnt", i),  32'(w_hitCnt),  32'(tv[i].eHit));
            check($sformatf("row%0d MissCnt", i), 32'(w_missCnt), 32'(tv[i].eMiss));
`endif
        end

        // Reset in the second BUSY cycle, stray MemAck one cycle later.
        @(negedge r_clk);
        drive(1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("rst detect StallM", 32'(w_stallM), 32'd1);
        @(negedge r_clk);
        #1;
        check("rst busy1 MemReq", 32'(w_memReq), 32'd1);
        check("rst busy1 MemAddr", w_memAddr, 32'h600);
        @(negedge r_clk);
        r_rst = 1'b1;
        #1;
        check("rst busy2 MemReq", 32'(w_memReq), 32'd1);
        @(negedge r_clk);
        r_rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h77);
        #1;
        check("after rst StallM",      32'(w_stallM),      32'd0);
        check("after rst MemReq",      32'(w_memReq),      32'd0);
        check("after rst MemWe",       32'(w_memWe),       32'd0);
        check("after rst MemAddr",     w_memAddr,          32'h0);
        check("after rst MemWData",    w_memWData,         32'h0);
        check("after rst FillEn",      32'(w_fillEn),      32'd0);
        check("after rst RefillValid", 32'(w_refillValid), 32'd0);
        check("after rst RefillData",  w_refillData,       32'h0);
`ifdef DCACHE_PERF_CNT_EN
        check("after rst HitCnt",  32'(w_hitCnt),  32'd0);
        check("after rst MissCnt", 32'(w_missCnt), 32'd0);
`endif
        @(negedge r_clk);
        r_memAck = 1'b0;
        #1;
        check("stray ack FillEn",      32'(w_fillEn),      32'd0);
        check("stray ack RefillValid", 32'(w_refillValid), 32'd0);
        check("stray ack MemReq",      32'(w_memReq),      32'd0);
        check("stray ack StallM",      32'(w_stallM),      32'd0);
        check("stray ack RefillData",  w_refillData,       32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule : tb_dcache_miss_ctrl
`default_nettype wire
